regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//   General-purpose register file answering the decode stage's operand reads.
//   Two asynchronous read ports (enable + address in, data out) feed the decode
//   stage; one synchronous write port is driven from write-back.
//   Storage is a single-write-port array (LUTRAM-friendly) and cannot be bulk
//   cleared, so an init FSM zeroes it one entry per cycle after reset.
//   busy_o stalls the pipeline until init completes.
// PARAMETERS
//   ADDR_W    5    register address width
//   DATA_W    32   register data width
//   NUM_REGS  32   entry count, always 1<<ADDR_W; entry 0 is hardwired zero
// PORTS
//   clk     in   1       rising-edge clock
//   rst     in   1       reset, synchronous, active-high
//   we      in   1       write enable from write-back
//   waddr   in   ADDR_W  write address
//   wdata   in   DATA_W  write data
//   re1     in   1       read-port-1 enable
//   raddr1  in   ADDR_W  read-port-1 address
//   rdata1  out  DATA_W  read-port-1 data (combinational)
//   re2     in   1       read-port-2 enable
//   raddr2  in   ADDR_W  read-port-2 address
//   rdata2  out  DATA_W  read-port-2 data (combinational)
//   busy_o  out  1       registered; high while the init FSM is active
// BEHAVIOUR
//   - FSM states: INIT, RUN. The FSM state, init_cnt and busy_o are registered.
//   - Reset: rst high at a clock edge sets state=INIT, init_cnt=1, busy_o=1.
//     - This holds for every cycle rst is high, including mid-RUN.
//     - Array contents are not altered while rst is high.
//   - INIT (rst low):
//     - Each edge writes mem[init_cnt]=0 and increments init_cnt.
//     - At the edge that writes entry NUM_REGS-1, the FSM goes to RUN and busy_o goes to 0.
//     - busy_o is therefore 1 for exactly NUM_REGS-1 (31) edges after rst falls.
//     - we is ignored; write-back writes are dropped, since the pipeline is stalled.
//   - RUN: at each edge with we=1 and waddr!=0, mem[waddr] <= wdata. Writes to entry 0 are dropped.
//   - Read port n: rdata_n is selected combinationally, first matching rule wins:
//     - rst=1 or busy_o=1 -> 0
//     - re_n=0 -> 0
//     - raddr_n==0 -> 0
//     - we=1 and waddr==raddr_n (and state RUN) -> wdata (write-to-read bypass, same cycle)
//     - otherwise -> mem[raddr_n]
//   - Both ports are fully independent. The same address on both ports returns identical data, including bypass.
//   - Latency: reads 0 cycles; writes are visible through the array on the next cycle and through bypass in the same cycle.
//   - init_cnt is ADDR_W bits wide and is not used outside INIT, so it has no wrap concern.
// TESTING
//   1. rst=1 for 3 cycles, then 0 -> busy_o=1 for 31 edges then 0; all 32 addresses read 0 on both ports.
//   2. RUN: we=1 waddr=5 wdata=0xDEADBEEF for 1 cycle; next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF.
//   3. Same cycle: we=1 waddr=7 wdata=0x12345678, re1=re2=1 raddr1=raddr2=7 -> both ports 0x12345678 before the edge.
//   4. we=1 waddr=0 wdata=0xFFFFFFFF; same and next cycle re1=1 raddr1=0 -> rdata1=0 both times.
//   5. r5=0xDEADBEEF stored; re1=0 raddr1=5 -> rdata1=0; re2=1 raddr2=5 -> rdata2=0xDEADBEEF.
//   6. Mid-RUN with r5=0xDEADBEEF: rst=1 for 1 cycle -> busy_o=1.
//      During INIT, we=1 waddr=9 wdata=0xA5A5A5A5 is ignored.
//      After busy_o falls, r5 and r9 both read 0.

Source files
------------

// File: rtl/regfile_if.sv
// Register-file bus: write-back write port, two decode read ports, and the init stall.
interface regfile_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              busy_o;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, busy_o
  );
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, busy_o
  );
endinterface

// File: rtl/regfile.sv
// 2R1W register file with entry 0 hardwired to zero and a post-reset
// init sweep that clears the single-write-port array one entry per cycle.
module regfile_rd_port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              blk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              byp_we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rdata
);
  always_comb begin
    rdata = '0;
    if (!blk && re && raddr != '0) begin
      if (byp_we && waddr == raddr) rdata = wdata;
      else                          rdata = mem_data;
    end
  end
endmodule

module regfile #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 1 << ADDR_W
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int NUM_RD = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              busy_q;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [NUM_RD-1:0]             re_v;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] mem_rd_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= ADDR_W'(1);
      busy_q   <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(NUM_REGS - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // One shared write port: the init sweep owns it during INIT, write-back during RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_cnt;
    wr_data = '0;
    if (!rst) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (bus.we && bus.waddr != '0) begin
        wr_en   = 1'b1;
        wr_addr = bus.waddr;
        wr_data = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign re_v    = {bus.re2, bus.re1};
  assign raddr_v = {bus.raddr2, bus.raddr1};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign mem_rd_v[i] = mem[raddr_v[i]];
    regfile_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
      .blk      (rst | busy_q),
      .re       (re_v[i]),
      .raddr    (raddr_v[i]),
      .byp_we   (bus.we && state == RUN),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .mem_data (mem_rd_v[i]),
      .rdata    (rdata_v[i])
    );
  end

  assign bus.rdata1 = rdata_v[0];
  assign bus.rdata2 = rdata_v[1];
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_regfile.sv
// Directed regfile bench: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_regfile;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // sel: 0 = rdata1, 1 = rdata2, 2 = busy_o
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic chk_now(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0:       act = bus.rdata1;
        1:       act = bus.rdata2;
        default: act = {31'd0, bus.busy_o};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle_bus();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0;
    bus.re2 = 1'b0; bus.raddr2 = '0;
  endtask

  task automatic wait_not_busy(input int max_cyc);
    int n;
    n = 0;
    while (bus.busy_o !== 1'b0 && n < max_cyc) begin
      cyc();
      n++;
    end
    chk_now("busy_wait_expired", {31'd0, bus.busy_o}, 32'd0);
  endtask

  // rst already low; walk the 31-edge init window, optionally firing write-back at r9.
  task automatic init_window(input bit wb_noise);
    bus.re1 = 1'b1;
    bus.raddr1 = 5'd3;
    if (wb_noise) begin
      bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5A5A5;
    end
    push("busy_k0", 2, 32'd1);
    push("rd_during_init_k0", 0, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      cyc();
      if (k == 31) bus.we = 1'b0;
      push($sformatf("busy_k%0d", k), 2, (k < 31) ? 32'd1 : 32'd0);
      if (k < 31) push($sformatf("rd_during_init_k%0d", k), 0, 32'd0);
    end
  endtask

  initial begin
    idle_bus();
    // 1: reset, init sweep, everything reads zero
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_now("rst_state_busy", {31'd0, bus.busy_o}, 32'd1);
      bus.re1 = 1'b1; bus.raddr1 = 5'd5;
      #1;
      chk_now("rst_state_rd", bus.rdata1, 32'd0);
      push("busy_in_rst", 2, 32'd1);
      push("rd_in_rst", 0, 32'd0);
    end
    rst = 1'b0;
    init_window(1'b0);
    wait_not_busy(40);
    for (int i = 0; i < 32; i++) begin
      bus.re1 = 1'b1; bus.raddr1 = 5'(i);
      bus.re2 = 1'b1; bus.raddr2 = 5'(31 - i);
      push($sformatf("zero_p1_r%0d", i), 0, 32'd0);
      push($sformatf("zero_p2_r%0d", 31 - i), 1, 32'd0);
      cyc();
    end

    // 2: write r5, read back through the array next cycle
    idle_bus();
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    cyc();
    idle_bus();
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    push("r5_array", 0, 32'hDEADBEEF);
    cyc();

    // 3: same-cycle bypass on both ports, then array read
    idle_bus();
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    push("r7_bypass_p1", 0, 32'h12345678);
    push("r7_bypass_p2", 1, 32'h12345678);
    cyc();
    bus.we = 1'b0;
    push("r7_array_p1", 0, 32'h12345678);
    push("r7_array_p2", 1, 32'h12345678);
    cyc();

    // write to one reg while reading another: no false bypass
    bus.we = 1'b1; bus.waddr = 5'd8; bus.wdata = 32'h0BADF00D;
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd7;
    push("no_byp_p1", 0, 32'hDEADBEEF);
    push("no_byp_p2", 1, 32'h12345678);
    cyc();

    // 4: writes to r0 are dropped, no bypass either
    idle_bus();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    push("r0_same_p1", 0, 32'd0);
    push("r0_same_p2", 1, 32'd0);
    cyc();
    bus.we = 1'b0;
    push("r0_next_p1", 0, 32'd0);
    cyc();

    // 5: read enable gates each port independently
    idle_bus();
    bus.re1 = 1'b0; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    push("re1_off", 0, 32'd0);
    push("re2_on", 1, 32'hDEADBEEF);
    cyc();

    // 6: mid-RUN reset re-clears the array and ignores write-back during init
    idle_bus();
    rst = 1'b1;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    push("rd_mid_rst", 1, 32'd0);
    cyc();
    push("busy_mid_rst", 2, 32'd1);
    rst = 1'b0;
    idle_bus();
    init_window(1'b1);
    idle_bus();
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    push("r5_cleared", 0, 32'd0);
    push("r9_cleared", 1, 32'd0);
    cyc();

    idle_bus();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
